reg_bus_master: RTL and testbench
=================================

REG_BUS_MASTER -- requirements
Module: reg_bus_master

Interface
REQ-001 Parameter: POLL_MAX, default 1023, maximum number of poll reads before timeout (1..1023).
REQ-002 clk_i  in  1  clock; all state changes on rising edge.
REQ-003 rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid_i  in  1  command request valid.
REQ-005 cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o.
REQ-006 cmd_wr_i  in  1  1 = write, 0 = read.
REQ-007 cmd_poll_i  in  1  1 = poll-read (ignored when cmd_wr_i=1).
REQ-008 cmd_addr_i  in  3  register address.
REQ-009 cmd_wdata_i  in  16  write data, or poll compare value.
REQ-010 cmd_mask_i  in  16  poll mask.
REQ-011 rsp_valid_o  out  1  response valid.
REQ-012 rsp_ready_i  in  1  response consumed when rsp_valid_o & rsp_ready_i.
REQ-013 rsp_rdata_o  out  16  read data (0 for writes).
REQ-014 rsp_timeout_o  out  1  poll ended without match.
REQ-015 acc_en_o, wr_en_o  out  1 each  register-bus access strobe and write qualifier.
REQ-016 addr_o  out  3; wdata_o  out  16  register-bus address and write data.
REQ-017 rdata_i  in  16  register-bus read data, combinational, valid during the access cycle.

Function
REQ-018 FSM states: IDLE, ACCESS, GAP, RESP; cmd_ready_o=1 only in IDLE.
REQ-019 IDLE: on handshake, latch wr, poll, addr, wdata, mask; clear poll counter; go to ACCESS.
REQ-020 ACCESS lasts exactly one cycle: acc_en_o=1, wr_en_o=latched wr, addr_o/wdata_o=latched values; outside ACCESS all four bus outputs are 0.
REQ-021 Read (poll=0): rdata_i sampled at end of ACCESS into rsp_rdata_o; go to RESP.
REQ-022 Write: rsp_rdata_o=0, rsp_timeout_o=0; go to RESP.
REQ-023 Latency: handshake in cycle N -> access in N+1 -> rsp_valid_o=1 from N+2.
REQ-024 Poll: in ACCESS, match = ((rdata_i & mask) == (wdata & mask)); match -> capture rdata_i, timeout=0, go to RESP.
REQ-025 Poll mismatch: counter increments (10-bit); if the new count == POLL_MAX, capture rdata_i, timeout=1, go to RESP; otherwise go to GAP.
REQ-026 GAP: one idle cycle (acc_en_o=0), then ACCESS; poll reads therefore occur every 2 cycles.
REQ-027 mask=0 matches on the first read.
REQ-028 RESP: rsp_valid_o=1; rsp_rdata_o and rsp_timeout_o held stable until rsp_ready_i; on handshake go to IDLE.
REQ-029 No back-to-back acceptance: next cmd accepted earliest the cycle after the response handshake.
REQ-030 Write to address 5 issues exactly one acc_en_o cycle (command pulse semantics).

Reset
REQ-031 Reset: state=IDLE; cmd_ready_o=0 during reset, 1 the first cycle after release.
REQ-032 Reset: rsp_valid_o=0, rsp_rdata_o=0, rsp_timeout_o=0, acc_en_o=0, wr_en_o=0, addr_o=0, wdata_o=0, counter=0.
REQ-033 Reset asserted mid-access or mid-poll aborts immediately; no response is produced for the aborted command.

Structure
REQ-034 Shared package: state enum; register address constants CTRL0=0, PWM_MODE=1, CNT_MODE0=2, CNT_MODE1=3, ACT_CNT=4, CMD=5, CAPTURED=6.
REQ-035 Single flat module; no sub-module.

Verification
REQ-036 Write addr 1, data 0x3155 -> one cycle acc_en_o=1, wr_en_o=1, addr_o=1, wdata_o=0x3155 at N+1; rsp at N+2 with rdata=0.
REQ-037 Read addr 1 after REQ-036 with responder attached -> rsp_rdata_o=0x3155, timeout=0.
REQ-038 Poll addr 6, mask 0x1000, cmp 0x1000; tm_running set after 3rd read -> exactly 4 reads, 2 cycles apart, rsp_rdata_o bit12=1, timeout=0.
REQ-039 Poll with POLL_MAX=4, never matching -> exactly 4 reads, rsp_timeout_o=1.
REQ-040 rsp_ready_i held low 5 cycles -> rsp_valid_o and data stable, cmd_ready_o=0, no bus activity.
REQ-041 rstn_i low during GAP of a poll -> all outputs 0 next evaluation, no response, new read accepted after release.

Source files
------------

// File: rtl/reg_bus_master_pkg.sv
// Shared types and register map for the register-bus command master.
package reg_bus_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_GAP,
    ST_RESP
  } state_e;

  localparam logic [2:0] ADDR_CTRL0     = 3'd0;
  localparam logic [2:0] ADDR_PWM_MODE  = 3'd1;
  localparam logic [2:0] ADDR_CNT_MODE0 = 3'd2;
  localparam logic [2:0] ADDR_CNT_MODE1 = 3'd3;
  localparam logic [2:0] ADDR_ACT_CNT   = 3'd4;
  localparam logic [2:0] ADDR_CMD       = 3'd5;
  localparam logic [2:0] ADDR_CAPTURED  = 3'd6;

  function automatic logic poll_match(input logic [15:0] rdata,
                                      input logic [15:0] cmp,
                                      input logic [15:0] mask);
    return ((rdata & mask) == (cmp & mask));
  endfunction

endpackage

// File: rtl/reg_bus_master.sv
// Command-driven register-bus master: single read/write accesses and
// masked poll-reads with a bounded retry count.
module reg_bus_master
  import reg_bus_master_pkg::*;
#(
  parameter int unsigned POLL_MAX = 1023
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_wr_i,
  input  logic        cmd_poll_i,
  input  logic [2:0]  cmd_addr_i,
  input  logic [15:0] cmd_wdata_i,
  input  logic [15:0] cmd_mask_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_rdata_o,
  output logic        rsp_timeout_o,
  output logic        acc_en_o,
  output logic        wr_en_o,
  output logic [2:0]  addr_o,
  output logic [15:0] wdata_o,
  input  logic [15:0] rdata_i
);

  localparam logic [9:0] POLL_LIMIT = 10'(POLL_MAX);

  state_e      state_q;
  logic        wr_q;
  logic        poll_q;
  logic [2:0]  addr_q;
  logic [15:0] wdata_q;
  logic [15:0] mask_q;
  logic [9:0]  cnt_q;
  logic [9:0]  cnt_d;
  logic        hit;

  logic        rsp_valid_q;
  logic [15:0] rsp_rdata_q;
  logic        rsp_timeout_q;
  logic        acc_en_q;
  logic        bus_wr_q;
  logic [2:0]  bus_addr_q;
  logic [15:0] bus_wdata_q;

  always_comb begin
    cnt_d = cnt_q + 10'd1;
    hit   = poll_match(rdata_i, wdata_q, mask_q);
  end

  // Bus outputs are registered, so they are loaded on the edge entering ACCESS.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      wr_q          <= 1'b0;
      poll_q        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      mask_q        <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      acc_en_q      <= 1'b0;
      bus_wr_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
    end else begin
      acc_en_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            wr_q        <= cmd_wr_i;
            poll_q      <= cmd_poll_i & ~cmd_wr_i;
            addr_q      <= cmd_addr_i;
            wdata_q     <= cmd_wdata_i;
            mask_q      <= cmd_mask_i;
            cnt_q       <= '0;
            acc_en_q    <= 1'b1;
            bus_wr_q    <= cmd_wr_i;
            bus_addr_q  <= cmd_addr_i;
            bus_wdata_q <= cmd_wdata_i;
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (wr_q) begin
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_RESP;
          end else if (!poll_q || hit) begin
            rsp_rdata_q   <= rdata_i;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_RESP;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == POLL_LIMIT) begin
              rsp_rdata_q   <= rdata_i;
              rsp_timeout_q <= 1'b1;
              rsp_valid_q   <= 1'b1;
              state_q       <= ST_RESP;
            end else begin
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          acc_en_q    <= 1'b1;
          bus_wr_q    <= wr_q;
          bus_addr_q  <= addr_q;
          bus_wdata_q <= wdata_q;
          state_q     <= ST_ACCESS;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Gated by reset so no command can be offered while reset is held.
  assign cmd_ready_o   = rstn_i & (state_q == ST_IDLE);
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign acc_en_o      = acc_en_q;
  assign wr_en_o       = bus_wr_q;
  assign addr_o        = bus_addr_q;
  assign wdata_o       = bus_wdata_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master with a small register-file responder.
module tb_reg_bus_master;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;

  logic        cmd_valid_i = 1'b0, cmd_wr_i = 1'b0, cmd_poll_i = 1'b0;
  logic [2:0]  cmd_addr_i = '0;
  logic [15:0] cmd_wdata_i = '0, cmd_mask_i = '0;
  logic        rsp_ready_i = 1'b0;
  logic        cmd_ready_o, rsp_valid_o, rsp_timeout_o, acc_en_o, wr_en_o;
  logic [15:0] rsp_rdata_o, wdata_o, rdata_i;
  logic [2:0]  addr_o;

  logic        cmd_valid4 = 1'b0, cmd_wr4 = 1'b0, cmd_poll4 = 1'b0;
  logic [2:0]  cmd_addr4 = '0;
  logic [15:0] cmd_wdata4 = '0, cmd_mask4 = '0;
  logic        rsp_ready4 = 1'b0;
  logic        cmd_ready4, rsp_valid4, rsp_timeout4, acc_en4, wr_en4;
  logic [15:0] rsp_rdata4, wdata4, rdata4;
  logic [2:0]  addr4;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_t[$];
  logic [15:0] regs [8] = '{default: 16'h0000};
  int          rd6_cnt = 0;
  logic        got;

  reg_bus_master dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
    .cmd_poll_i(cmd_poll_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .cmd_mask_i(cmd_mask_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_timeout_o(rsp_timeout_o), .acc_en_o(acc_en_o),
    .wr_en_o(wr_en_o), .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i)
  );

  reg_bus_master #(.POLL_MAX(4)) dut4 (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cmd_valid_i(cmd_valid4), .cmd_ready_o(cmd_ready4), .cmd_wr_i(cmd_wr4),
    .cmd_poll_i(cmd_poll4), .cmd_addr_i(cmd_addr4), .cmd_wdata_i(cmd_wdata4),
    .cmd_mask_i(cmd_mask4), .rsp_valid_o(rsp_valid4), .rsp_ready_i(rsp_ready4),
    .rsp_rdata_o(rsp_rdata4), .rsp_timeout_o(rsp_timeout4), .acc_en_o(acc_en4),
    .wr_en_o(wr_en4), .addr_o(addr4), .wdata_o(wdata4), .rdata_i(rdata4)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (acc_en_o && wr_en_o) regs[addr_o] <= wdata_o;
    if (acc_en_o && !wr_en_o && addr_o == 3'd6) rd6_cnt <= rd6_cnt + 1;
  end

  // Address 6 models a status register whose bit 12 rises after three reads.
  always_comb begin
    if (addr_o == 3'd6) rdata_i = (rd6_cnt >= 3) ? 16'h1040 : 16'h0040;
    else                rdata_i = regs[addr_o];
  end

  assign rdata4 = 16'h00A0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic wr, input logic poll, input logic [2:0] a,
                         input logic [15:0] wd, input logic [15:0] mk, input int budget);
    acc_t.delete();
    got = 1'b0;
    check("ready_before_cmd", cmd_ready_o, 1'b1);
    cmd_valid_i = 1'b1; cmd_wr_i = wr; cmd_poll_i = poll;
    cmd_addr_i = a; cmd_wdata_i = wd; cmd_mask_i = mk;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
      if (acc_en_o) acc_t.push_back(cyc);
      if (rsp_valid_o) begin got = 1'b1; break; end
    end
    check("rsp_within_budget", got, 1'b1);
  endtask

  task automatic ack();
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    check("rsp_valid_after_ack", rsp_valid_o, 1'b0);
    check("ready_after_ack", cmd_ready_o, 1'b1);
  endtask

  initial begin
    int first4, last4, n4;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_cmd_ready", cmd_ready_o, 1'b0);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_rsp_rdata", rsp_rdata_o, 16'h0);
    check("rst_timeout", rsp_timeout_o, 1'b0);
    check("rst_bus", {acc_en_o, wr_en_o, addr_o, wdata_o}, 21'h0);
    @(negedge clk_i); rstn_i = 1'b1; #1;
    check("ready_after_release", cmd_ready_o, 1'b1);
    @(posedge clk_i); #1;

    // Write addr 1 = 0x3155, cycle by cycle
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b1; cmd_poll_i = 1'b0;
    cmd_addr_i = 3'd1; cmd_wdata_i = 16'h3155; cmd_mask_i = 16'h0;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    check("wr_access_bus", {acc_en_o, wr_en_o, addr_o, wdata_o}, {1'b1, 1'b1, 3'd1, 16'h3155});
    check("wr_access_ready", cmd_ready_o, 1'b0);
    check("wr_access_rsp", rsp_valid_o, 1'b0);
    @(posedge clk_i); #1;
    check("wr_rsp_bus_idle", {acc_en_o, wr_en_o, addr_o, wdata_o}, 21'h0);
    check("wr_rsp_valid", rsp_valid_o, 1'b1);
    check("wr_rsp_rdata", rsp_rdata_o, 16'h0);
    check("wr_rsp_timeout", rsp_timeout_o, 1'b0);
    ack();

    // Read back, with response stalled five cycles
    run_cmd(1'b0, 1'b0, 3'd1, 16'h0, 16'h0, 20);
    check("rd_reads", acc_t.size(), 1);
    check("rd_rdata", rsp_rdata_o, 16'h3155);
    check("rd_timeout", rsp_timeout_o, 1'b0);
    repeat (5) begin
      @(posedge clk_i); #1;
      check("stall_valid", rsp_valid_o, 1'b1);
      check("stall_rdata", rsp_rdata_o, 16'h3155);
      check("stall_ready", cmd_ready_o, 1'b0);
      check("stall_bus", acc_en_o, 1'b0);
    end
    ack();

    // Command register write: single pulse
    run_cmd(1'b1, 1'b0, 3'd5, 16'h0001, 16'h0, 20);
    check("cmd_wr_pulses", acc_t.size(), 1);
    ack();

    // Poll status until bit 12 rises
    run_cmd(1'b0, 1'b1, 3'd6, 16'h1000, 16'h1000, 100);
    check("poll_reads", acc_t.size(), 4);
    check("poll_spacing", acc_t[3] - acc_t[0], 6);
    check("poll_rdata", rsp_rdata_o, 16'h1040);
    check("poll_timeout", rsp_timeout_o, 1'b0);
    ack();

    // Poll timeout on POLL_MAX=4 instance
    check("ready4", cmd_ready4, 1'b1);
    cmd_valid4 = 1'b1; cmd_wr4 = 1'b0; cmd_poll4 = 1'b1;
    cmd_addr4 = 3'd3; cmd_wdata4 = 16'h0001; cmd_mask4 = 16'h0001;
    n4 = 0; first4 = 0; last4 = 0; got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_i); #1;
      cmd_valid4 = 1'b0;
      if (acc_en4) begin
        if (n4 == 0) first4 = cyc;
        last4 = cyc;
        n4++;
      end
      if (rsp_valid4) begin got = 1'b1; break; end
    end
    check("to_rsp_within_budget", got, 1'b1);
    check("to_reads", n4, 4);
    check("to_spacing", last4 - first4, 6);
    check("to_timeout", rsp_timeout4, 1'b1);
    check("to_rdata", rsp_rdata4, 16'h00A0);
    rsp_ready4 = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready4 = 1'b0;
    check("to_ack", rsp_valid4, 1'b0);

    // Mask 0 matches on first read
    run_cmd(1'b1, 1'b0, 3'd2, 16'h0BEE, 16'h0, 20);
    ack();
    run_cmd(1'b0, 1'b1, 3'd2, 16'hFFFF, 16'h0000, 20);
    check("mask0_reads", acc_t.size(), 1);
    check("mask0_rdata", rsp_rdata_o, 16'h0BEE);
    check("mask0_timeout", rsp_timeout_o, 1'b0);
    ack();

    // Reset during the gap of a never-matching poll
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b0; cmd_poll_i = 1'b1;
    cmd_addr_i = 3'd2; cmd_wdata_i = 16'h8000; cmd_mask_i = 16'h8000;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    check("abort_access", acc_en_o, 1'b1);
    @(posedge clk_i); #1;
    check("abort_gap", acc_en_o, 1'b0);
    rstn_i = 1'b0; #1;
    check("abort_bus", {acc_en_o, wr_en_o, addr_o, wdata_o}, 21'h0);
    check("abort_rsp", {rsp_valid_o, rsp_timeout_o, rsp_rdata_o}, 18'h0);
    check("abort_ready", cmd_ready_o, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    check("abort_no_rsp", rsp_valid_o, 1'b0);
    @(negedge clk_i); rstn_i = 1'b1; #1;
    check("abort_ready_release", cmd_ready_o, 1'b1);
    @(posedge clk_i); #1;
    run_cmd(1'b0, 1'b0, 3'd1, 16'h0, 16'h0, 20);
    check("post_rst_rdata", rsp_rdata_o, 16'h3155);
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
